relu_act_seq: RTL

- Control sequencer that drives the enable and clear side of a two-phase ReLU activation stage: clear, then calc-enable (result into internal X), then output-enable (Y <= X).
- Accepts convolution results on a valid/ready stream and steps each value through the stage with clr / en_act / en_act_out.
- Captures the stage's Y result and presents it on a valid/ready output stream.
- Counts pixels per feature map, clears the stage at frame boundaries, and pulses frame_done.

---
 rtl/relu_act_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/relu_act_seq.sv
// Sequencer for a two-phase ReLU stage: clear, calc-enable, output-enable, capture.
// Streams one sample at a time, counts pixels per frame and clears the stage between frames.
module relu_act_seq #(
  parameter int In_d_W = 18,
  parameter int N_PIX  = 676,
  parameter int CNT_W  = $clog2(N_PIX + 1)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [In_d_W-1:0] in_data,
  output logic                     act_clr,
  output logic                     en_act,
  output logic                     en_act_out,
  output logic signed [In_d_W-1:0] act_A,
  input  logic signed [In_d_W-1:0] act_Y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [In_d_W-1:0] out_data,
  output logic [CNT_W-1:0]         pix_cnt,
  output logic                     frame_done
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_CALC = 3'd2,
    S_XFER = 3'd3,
    S_CAPT = 3'd4,
    S_OUT  = 3'd5,
    S_FEND = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_PIX - 1);

  state_t state_q, state_d;

  logic                     in_ready_q,   in_ready_d;
  logic                     act_clr_q,    act_clr_d;
  logic                     en_act_q,     en_act_d;
  logic                     en_act_out_q, en_act_out_d;
  logic signed [In_d_W-1:0] act_a_q,      act_a_d;
  logic                     out_valid_q,  out_valid_d;
  logic signed [In_d_W-1:0] out_data_q,   out_data_d;
  logic [CNT_W-1:0]         pix_cnt_q,    pix_cnt_d;
  logic                     frame_done_q, frame_done_d;

  logic in_fire;
  logic out_fire;
  logic last_pix;

  assign in_fire  = (state_q == S_IDLE) && in_valid;
  assign out_fire = (state_q == S_OUT) && out_ready;
  assign last_pix = (pix_cnt_q == LAST_PIX);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // Reset leaves act_clr low, so INIT spends one extra cycle raising it before moving on.
      S_INIT: if (act_clr_q) state_d = S_IDLE;
      S_IDLE: if (in_valid) state_d = S_CALC;
      S_CALC: state_d = S_XFER;
      S_XFER: state_d = S_CAPT;
      S_CAPT: state_d = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          state_d = last_pix ? S_FEND : S_IDLE;
        end
      end
      S_FEND: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Control outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    in_ready_d   = (state_d == S_IDLE);
    act_clr_d    = (state_d == S_INIT) || (state_d == S_FEND);
    en_act_d     = (state_d == S_CALC);
    en_act_out_d = (state_d == S_XFER);
    out_valid_d  = (state_d == S_OUT);
    frame_done_d = (state_d == S_FEND);

    act_a_d = act_a_q;
    if (in_fire) begin
      act_a_d = in_data;
    end

    out_data_d = out_data_q;
    if (state_q == S_CAPT) begin
      out_data_d = act_Y;
    end

    pix_cnt_d = pix_cnt_q;
    if (out_fire) begin
      pix_cnt_d = last_pix ? '0 : pix_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      in_ready_q   <= 1'b0;
      act_clr_q    <= 1'b0;
      en_act_q     <= 1'b0;
      en_act_out_q <= 1'b0;
      act_a_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      in_ready_q   <= in_ready_d;
      act_clr_q    <= act_clr_d;
      en_act_q     <= en_act_d;
      en_act_out_q <= en_act_out_d;
      act_a_q      <= act_a_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign act_clr    = act_clr_q;
  assign en_act     = en_act_q;
  assign en_act_out = en_act_out_q;
  assign act_A      = act_a_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign pix_cnt    = pix_cnt_q;
  assign frame_done = frame_done_q;

endmodule
